// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit and its prefetch FIFO.
// An entry bundles the fetched word, the PC it came from, and an access-fault flag.
package fetch_pkg;

  localparam logic [31:0] PC_STEP = 32'd4;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        fault;
  } fetch_entry_t;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

  // A faulting fetch never exposes whatever the ROM drove on its data bus.
  function automatic fetch_entry_t make_entry(input logic [31:0] data,
                                              input logic [31:0] pc,
                                              input logic        accessable);
    fetch_entry_t e;
    e.inst  = accessable ? data : 32'h0;
    e.pc    = pc;
    e.fault = ~accessable;
    return e;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries with a same-cycle flush.
// The head is read straight from registered storage and reads as all-zero when empty.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wr_entry,
  output logic         full,
  output logic         empty,
  output fetch_entry_t head
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW-1:0]  wr_ptr_reg;
  logic [AW-1:0]  rd_ptr_reg;
  logic [AW:0]    count_reg;
  fetch_entry_t   mem_reg [DEPTH];
  logic [DEPTH-1:0] wr_sel;
  logic           do_push;
  logic           do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty & ~flush;
  // A pop frees the slot that a simultaneous push into a full FIFO needs.
  assign do_push = push & ~flush & (~full | do_pop);

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_sel
      assign wr_sel[gi] = do_push & (wr_ptr_reg == AW'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_sel[i]) begin
          mem_reg[i] <= wr_entry;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign head = empty ? fetch_entry_t'('0) : mem_reg[rd_ptr_reg];

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: walks the ROM from a fetch PC into a prefetch FIFO,
// stops after an inaccessible fetch, and restarts on a CPU redirect.
module inst_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h00000000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data,
  input  logic        rom_accessable,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_fault
);

  logic [31:0]  fetch_pc_reg;
  fetch_state_t state_reg;
  logic         fifo_full;
  logic         fifo_empty;
  fetch_entry_t head;
  fetch_entry_t wr_entry;
  logic         pop;
  logic         push;

  assign rom_addr   = fetch_pc_reg;
  assign inst_valid = ~fifo_empty;
  assign pop        = inst_valid & inst_ready;
  // A redirect wins over everything: no fetch is captured in the cycle it arrives.
  assign push       = (state_reg == RUN) & (~fifo_full | pop) & ~redirect_valid;
  assign wr_entry   = make_entry(rom_data, fetch_pc_reg, rom_accessable);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_reg <= RESET_PC;
      state_reg    <= RUN;
    end else if (redirect_valid) begin
      fetch_pc_reg <= redirect_pc;
      state_reg    <= RUN;
    end else if (push) begin
      if (rom_accessable) begin
        fetch_pc_reg <= fetch_pc_reg + PC_STEP;
      end else begin
        state_reg    <= HALT;
      end
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .pop      (pop),
    .flush    (redirect_valid),
    .wr_entry (wr_entry),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head     (head)
  );

  assign inst       = head.inst;
  assign inst_pc    = head.pc;
  assign inst_fault = head.fault;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: directed scenarios plus a random phase, checked every
// cycle against a queue-based model of the fetch/prefetch behaviour.
module tb_inst_fetch_unit;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic        rom_accessable;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_fault;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        fault;
  } ent_t;

  ent_t        q[$];
  logic [31:0] m_pc;
  bit          m_halt;

  inst_fetch_unit #(
    .RESET_PC   (32'h00000000),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .rom_accessable (rom_accessable),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_fault     (inst_fault)
  );

  always #5 clk = ~clk;

  // ROM map: boot stub at 0x0..0x8, a 16-word region at 0x00400000, two words at the top of memory.
  function automatic logic [32:0] rom_lookup(input logic [31:0] a);
    if (a[1:0] != 2'b00)                        return {1'b0, 32'hBAD00000 ^ a};
    if (a == 32'h0)                             return {1'b1, 32'h3c110040};
    if (a == 32'h4)                             return {1'b1, 32'h26310000};
    if (a == 32'h8)                             return {1'b1, 32'h02200008};
    if (a >= 32'h00400000 && a < 32'h00400040)  return {1'b1, 32'h24000000 | {16'h0, a[15:0]}};
    if (a >= 32'hFFFFFFF8)                      return {1'b1, 32'hDEAD0000 | {16'h0, a[15:0]}};
    return {1'b0, 32'hBAD00000 ^ a};
  endfunction

  always_comb {rom_accessable, rom_data} = rom_lookup(rom_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_pc   = 32'h0;
    m_halt = 1'b0;
  endtask

  task automatic model_edge(input bit rdy, input bit rv, input logic [31:0] rpc);
    logic [32:0] r;
    bit popped;
    if (rv) begin
      q.delete();
      m_pc   = rpc;
      m_halt = 1'b0;
    end else begin
      popped = (q.size() != 0) && rdy;
      if (popped) void'(q.pop_front());
      if (!m_halt && q.size() < DEPTH) begin
        r = rom_lookup(m_pc);
        q.push_back('{inst: (r[32] ? r[31:0] : 32'h0), pc: m_pc, fault: ~r[32]});
        if (r[32]) m_pc = m_pc + 32'd4;
        else       m_halt = 1'b1;
      end
    end
  endtask

  task automatic check_all();
    bit ne;
    ne = (q.size() != 0);
    chk("inst_valid", {31'b0, inst_valid}, {31'b0, ne});
    chk("inst",       inst,    ne ? q[0].inst : 32'h0);
    chk("inst_pc",    inst_pc, ne ? q[0].pc   : 32'h0);
    chk("inst_fault", {31'b0, inst_fault}, {31'b0, (ne ? q[0].fault : 1'b0)});
    chk("rom_addr",   rom_addr, m_pc);
    chk("count_bound", {31'b0, (dut.u_fifo.count_reg <= DEPTH)}, 32'h1);
  endtask

  task automatic step(input bit rdy, input bit rv, input logic [31:0] rpc);
    inst_ready     = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    @(posedge clk);
    model_edge(rdy, rv, rpc);
    @(negedge clk);
    check_all();
    $display("t=%0t rdy=%0b rv=%0b rpc=%h -> valid=%0b inst=%h pc=%h fault=%0b rom_addr=%h",
             $time, rdy, rv, rpc, inst_valid, inst, inst_pc, inst_fault, rom_addr);
  endtask

  logic [31:0] targets [8] = '{32'h0, 32'h4, 32'h8, 32'h0040000C, 32'h00400002,
                                32'h0000000C, 32'hFFFFFFF8, 32'h00400038};

  initial begin
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_all();
    reset = 1'b1;

    // Back-pressure from reset: two entries captured, fetch PC parked at 0x8.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 32'h0);
    chk("sat_rom_addr", rom_addr, 32'h00000008);
    chk("sat_head_pc", inst_pc, 32'h00000000);
    step(1'b1, 1'b0, 32'h0);
    chk("rel_head_pc", inst_pc, 32'h00000004);
    // Runs on into the unmapped 0xC and halts.
    for (int i = 0; i < 13; i++) step(1'b1, 1'b0, 32'h0);
    chk("halt_idle", {31'b0, inst_valid}, 32'h0);

    // Redirect to boot stub resumes with one bubble.
    step(1'b1, 1'b1, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    chk("boot_word0", inst, 32'h3c110040);
    step(1'b1, 1'b0, 32'h0);
    chk("boot_word1", inst, 32'h26310000);
    step(1'b1, 1'b0, 32'h0);
    chk("boot_word2", inst, 32'h02200008);

    // Fill from top of memory, then redirect while full with ready high.
    step(1'b0, 1'b1, 32'hFFFFFFF8);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0);
    chk("wrap_rom_addr", rom_addr, 32'h00000000);
    step(1'b1, 1'b1, 32'h00400000);
    chk("redir_bubble", {31'b0, inst_valid}, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    chk("redir_pc", inst_pc, 32'h00400000);
    chk("redir_word", inst, 32'h24000000);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h0);

    // PC wrap with ready high.
    step(1'b1, 1'b1, 32'hFFFFFFF8);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 32'h0);

    // Misaligned redirect: single fault entry, then halt.
    step(1'b1, 1'b1, 32'h00400002);
    step(1'b1, 1'b0, 32'h0);
    chk("misalign_pc", inst_pc, 32'h00400002);
    chk("misalign_fault", {31'b0, inst_fault}, 32'h1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h0);

    // Random phase.
    for (int i = 0; i < 400; i++) begin
      bit rv;
      rv = ($urandom_range(0, 11) == 0);
      step($urandom_range(0, 3) != 0, rv, targets[$urandom_range(0, 7)]);
    end

    // Asynchronous reset with the FIFO half full.
    step(1'b0, 1'b1, 32'h00400000);
    step(1'b0, 1'b0, 32'h0);
    #2 reset = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    reset = 1'b1;
    step(1'b1, 1'b0, 32'h0);
    chk("restart_pc", inst_pc, 32'h00000000);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
